// File: rtl/init_reg_readback_pkg.sv
// rtl/init_reg_readback_pkg.sv - shared types and entry helpers for the init-table read-back verifier
package init_reg_readback_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  function automatic logic [31:0] entry_addr(input logic [63:0] entry);
    return entry[63:32];
  endfunction

  function automatic logic [31:0] entry_data(input logic [63:0] entry);
    return entry[31:0];
  endfunction

endpackage

// File: rtl/init_reg_readback.sv
// rtl/init_reg_readback.sv - walks the init table over APB reads and reports mismatches
module init_reg_readback
  import init_reg_readback_pkg::*;
#(
  parameter int N_INIT_REG     = 20,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          i_apb_clk,
  input  logic                          i_apb_rst_n,
  input  logic                          i_start,
  input  logic [N_INIT_REG-1:0][63:0]   i_init_reg,
  input  logic [N_INIT_REG-1:0]         i_skip_mask,
  output logic                          o_apb_psel,
  output logic                          o_apb_penable,
  output logic                          o_apb_pwrite,
  output logic [31:0]                   o_apb_paddr,
  input  logic                          i_apb_pready,
  input  logic [31:0]                   i_apb_prdata,
  input  logic                          i_apb_pslverr,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_pass,
  output logic [ERR_CNT_W-1:0]          o_err_cnt,
  output logic [$clog2(N_INIT_REG)-1:0] o_first_err_idx,
  output logic [31:0]                   o_first_err_data
);

  localparam int IDX_W = $clog2(N_INIT_REG);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, next_state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] disp_idx;
  logic [TMO_W-1:0] tmo_cnt;
  logic             last_entry;
  logic             tmo_hit;
  logic             access_end;
  logic             entry_fail;
  logic [31:0]      exp_data;

  // disp_idx is the entry about to be dispatched: 0 from IDLE, idx+1 from NEXT
  always_comb begin
    last_entry = (idx == IDX_W'(N_INIT_REG - 1));
    disp_idx   = (state == ST_IDLE) ? '0 : idx + 1'b1;
    exp_data   = entry_data(i_init_reg[idx]);
    tmo_hit    = !i_apb_pready && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    access_end = i_apb_pready || tmo_hit;
    entry_fail = tmo_hit || i_apb_pslverr || (i_apb_prdata != exp_data);
  end

  always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
    if (!i_apb_rst_n) state <= ST_IDLE;
    else              state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (i_start) next_state = i_skip_mask[disp_idx] ? ST_NEXT : ST_SETUP;
      ST_SETUP:  next_state = ST_ACCESS;
      ST_ACCESS: if (access_end) next_state = ST_NEXT;
      ST_NEXT: begin
        if (last_entry)                 next_state = ST_DONE;
        else if (i_skip_mask[disp_idx]) next_state = ST_NEXT;
        else                            next_state = ST_SETUP;
      end
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
    if (!i_apb_rst_n) begin
      idx              <= '0;
      tmo_cnt          <= '0;
      o_apb_paddr      <= '0;
      o_err_cnt        <= '0;
      o_first_err_idx  <= '0;
      o_first_err_data <= '0;
      o_pass           <= 1'b0;
    end else begin
      if (state == ST_IDLE && i_start) begin
        idx              <= '0;
        o_err_cnt        <= '0;
        o_first_err_idx  <= '0;
        o_first_err_data <= '0;
      end
      if (state == ST_NEXT && !last_entry) idx <= idx + 1'b1;
      if (next_state == ST_SETUP) o_apb_paddr <= entry_addr(i_init_reg[disp_idx]);

      if (state == ST_ACCESS && !access_end) tmo_cnt <= tmo_cnt + 1'b1;
      else                                   tmo_cnt <= '0;

      // first_err_* latch only on the first failure of the run
      if (state == ST_ACCESS && access_end && entry_fail) begin
        if (o_err_cnt != ERR_CNT_MAX) o_err_cnt <= o_err_cnt + 1'b1;
        if (o_err_cnt == '0) begin
          o_first_err_idx  <= idx;
          o_first_err_data <= i_apb_pready ? i_apb_prdata : 32'h0;
        end
      end
      if (state == ST_NEXT && last_entry) o_pass <= (o_err_cnt == '0);
    end
  end

  assign o_apb_psel    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign o_apb_penable = (state == ST_ACCESS);
  assign o_apb_pwrite  = 1'b0;
  assign o_busy        = (state != ST_IDLE);
  assign o_done        = (state == ST_DONE);

endmodule

// File: tb/tb_init_reg_readback.sv
// tb/tb_init_reg_readback.sv - directed self-checking bench for init_reg_readback
module tb_init_reg_readback;

  localparam int N   = 20;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [N-1:0][63:0] init_reg;
  logic [N-1:0]      skip_mask;
  logic              psel, penable, pwrite, pready, pslverr;
  logic [31:0]       paddr, prdata;
  logic              busy, done, pass;
  logic [7:0]        err_cnt;
  logic [4:0]        first_idx;
  logic [31:0]       first_data;

  logic [31:0]  corrupt [N];
  logic [N-1:0] slverr_m;
  logic [N-1:0] stall_m;
  int           wait_n;
  int           acc_cnt;
  logic [4:0]   kb;

  int errors = 0;
  int checks = 0;

  int   xfers, stab_err, pw_err, cyc;
  int   acc_per [N];
  logic [31:0] setup_addr;

  always #5 clk = ~clk;

  init_reg_readback #(.N_INIT_REG(N), .TIMEOUT_CYCLES(TMO)) dut (
    .i_apb_clk(clk), .i_apb_rst_n(rst_n), .i_start(start),
    .i_init_reg(init_reg), .i_skip_mask(skip_mask),
    .o_apb_psel(psel), .o_apb_penable(penable), .o_apb_pwrite(pwrite),
    .o_apb_paddr(paddr), .i_apb_pready(pready), .i_apb_prdata(prdata),
    .i_apb_pslverr(pslverr), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_err_cnt(err_cnt), .o_first_err_idx(first_idx), .o_first_err_data(first_data)
  );

  // APB slave: entry k lives at 0x1000_0000 + 4k
  assign kb      = paddr[6:2];
  assign prdata  = init_reg[kb][31:0] ^ corrupt[kb];
  assign pslverr = slverr_m[kb];
  assign pready  = psel && penable && !stall_m[kb] && (acc_cnt == wait_n);

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end

  task automatic clear_faults();
    for (int k = 0; k < N; k++) corrupt[k] = 32'h0;
    slverr_m  = '0;
    stall_m   = '0;
    skip_mask = '0;
    wait_n    = 0;
  endtask

  task automatic run_to_done(input int inject_at);
    xfers = 0; stab_err = 0; pw_err = 0; cyc = 0;
    for (int k = 0; k < N; k++) acc_per[k] = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (cyc == inject_at);
      if (psel && !penable) begin xfers++; setup_addr = paddr; end
      if (psel && penable) begin
        acc_per[kb]++;
        if (paddr !== setup_addr) stab_err++;
      end
      if (psel && pwrite) pw_err++;
      if (done) break;
    end
    start = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL done_timeout: got no done within %0d cycles", cyc); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (psel !== 1'b0) begin errors++; $display("FAIL rst_psel: got %b expected 0", psel); end
    checks++; if (penable !== 1'b0) begin errors++; $display("FAIL rst_penable: got %b expected 0", penable); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL rst_pass: got %b expected 0", pass); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (paddr !== 32'h0) begin errors++; $display("FAIL rst_paddr: got %h expected 0", paddr); end
    checks++; if (first_data !== 32'h0) begin errors++; $display("FAIL rst_first_data: got %h expected 0", first_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_match();
    clear_faults();
    run_to_done(0);
    checks++; if (cyc != 61) begin errors++; $display("FAIL match_done_cycle: got %0d expected 61", cyc); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL match_pass: got %b expected 1", pass); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL match_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (xfers != 20) begin errors++; $display("FAIL match_xfers: got %0d expected 20", xfers); end
    checks++; if (pw_err != 0) begin errors++; $display("FAIL match_pwrite: got %0d write cycles expected 0", pw_err); end
  endtask

  task automatic test_mismatch();
    clear_faults();
    corrupt[7]  = 32'h0000_0001;
    corrupt[12] = 32'h0000_0100;
    run_to_done(0);
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL mm_err_cnt: got %0d expected 2", err_cnt); end
    checks++; if (first_idx !== 5'd7) begin errors++; $display("FAIL mm_first_idx: got %0d expected 7", first_idx); end
    checks++; if (first_data !== 32'h0000_2328) begin errors++; $display("FAIL mm_first_data: got %h expected 00002328", first_data); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL mm_pass: got %b expected 0", pass); end
    checks++; if (cyc != 61) begin errors++; $display("FAIL mm_done_cycle: got %0d expected 61", cyc); end
  endtask

  task automatic test_skip_slverr();
    clear_faults();
    skip_mask   = 20'h80000;
    slverr_m[3] = 1'b1;
    run_to_done(0);
    checks++; if (xfers != 19) begin errors++; $display("FAIL skip_xfers: got %0d expected 19", xfers); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL skip_err_cnt: got %0d expected 1", err_cnt); end
    checks++; if (first_idx !== 5'd3) begin errors++; $display("FAIL skip_first_idx: got %0d expected 3", first_idx); end
    checks++; if (first_data !== 32'h5A00_0333) begin errors++; $display("FAIL skip_first_data: got %h expected 5a000333", first_data); end
    checks++; if (cyc != 59) begin errors++; $display("FAIL skip_done_cycle: got %0d expected 59", cyc); end
  endtask

  task automatic test_timeout();
    clear_faults();
    stall_m[0] = 1'b1;
    run_to_done(0);
    checks++; if (acc_per[0] != 16) begin errors++; $display("FAIL tmo_access_cycles: got %0d expected 16", acc_per[0]); end
    checks++; if (first_data !== 32'h0) begin errors++; $display("FAIL tmo_first_data: got %h expected 0", first_data); end
    checks++; if (first_idx !== 5'd0) begin errors++; $display("FAIL tmo_first_idx: got %0d expected 0", first_idx); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL tmo_err_cnt: got %0d expected 1", err_cnt); end
    checks++; if (xfers != 20) begin errors++; $display("FAIL tmo_xfers: got %0d expected 20", xfers); end
    checks++; if (cyc != 76) begin errors++; $display("FAIL tmo_done_cycle: got %0d expected 76", cyc); end
  endtask

  task automatic test_wait_states();
    clear_faults();
    wait_n = 2;
    run_to_done(0);
    checks++; if (cyc != 101) begin errors++; $display("FAIL ws_done_cycle: got %0d expected 101", cyc); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL ws_paddr_stable: got %0d changes expected 0", stab_err); end
    checks++; if (acc_per[19] != 3) begin errors++; $display("FAIL ws_access_cycles: got %0d expected 3", acc_per[19]); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ws_pass: got %b expected 1", pass); end
  endtask

  task automatic test_reset_restart();
    int n;
    int busy_after;
    clear_faults();
    corrupt[2] = 32'h0000_0010;
    n = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (n < 200 && !(psel && penable && kb == 5'd5)) begin
      @(negedge clk);
      n++;
    end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL rr_pre_err_cnt: got %0d expected 1", err_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (psel !== 1'b0) begin errors++; $display("FAIL rr_psel: got %b expected 0", psel); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rr_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rr_done: got %b expected 0", done); end
    rst_n = 1'b1;
    clear_faults();
    @(negedge clk);
    run_to_done(10);
    checks++; if (xfers != 20) begin errors++; $display("FAIL rr_xfers: got %0d expected 20", xfers); end
    checks++; if (cyc != 61) begin errors++; $display("FAIL rr_done_cycle: got %0d expected 61", cyc); end
    busy_after = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || done) busy_after++;
    end
    checks++; if (busy_after != 0) begin errors++; $display("FAIL rr_no_queued_run: got %0d busy cycles expected 0", busy_after); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int k = 0; k < N; k++)
      init_reg[k] = {32'h1000_0000 + 32'(k * 4), 32'h5A00_0000 + 32'(k * 32'h111)};
    init_reg[7][31:0] = 32'h0000_2329;
    clear_faults();
    test_reset();
    test_all_match();
    test_mismatch();
    test_skip_slverr();
    test_timeout();
    test_wait_states();
    test_reset_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/init_reg_readback.md
# init_reg_readback

Read-back verifier for the system initialization table. On `i_start` it walks the N_INIT_REG {addr, data} entries in index order and issues one APB read per entry, unless the entry is skipped. It compares each returned word with the expected data and reports pass/fail, an error count and the first mismatch. It sits beside the init-table writer on the same APB register fabric and is used after power-up and for bring-up diagnostics.

## Interface
Parameters:
- N_INIT_REG, 20, number of table entries
- TIMEOUT_CYCLES, 1024, maximum ACCESS-phase cycles waiting for `pready` before an entry is declared failed

Ports (one clock; reset is asynchronous and active-low):
- i_apb_clk  in  1  APB clock; all logic is in this domain
- i_apb_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  run request; sampled only in IDLE, ignored while busy
- i_init_reg  in  N_INIT_REG×64  entry k: [63:32] address, [31:0] expected data; held stable during a run
- i_skip_mask  in  N_INIT_REG  bit k=1 means entry k is not read (self-clearing or volatile registers)
- o_apb_psel  out  1  APB select
- o_apb_penable  out  1  APB enable
- o_apb_pwrite  out  1  constant 0
- o_apb_paddr  out  32  entry address
- i_apb_pready  in  1  APB ready
- i_apb_prdata  in  32  APB read data
- i_apb_pslverr  in  1  APB slave error
- o_busy  out  1  high from the cycle after start through DONE
- o_done  out  1  one-cycle pulse at the end of a run
- o_pass  out  1  1 when the last completed run had o_err_cnt==0
- o_err_cnt  out  8  failed entries in the last run; saturates at 255
- o_first_err_idx  out  $clog2(N_INIT_REG)  index of the first failed entry
- o_first_err_data  out  32  prdata of the first failure; 0 if that failure was a timeout

## Operation
- States: IDLE, SETUP, ACCESS, NEXT, DONE.
- IDLE:
  - i_start=1 → clear err_cnt, first_err_*, idx=0, then go to NEXT-evaluate.
  - Entry dispatch: if skip[idx], take a 1-cycle NEXT; otherwise go to SETUP.
- SETUP: psel=1, penable=0, paddr=entry addr. Always goes to ACCESS after one cycle.
- ACCESS: psel=1, penable=1, timeout counter increments.
  - pready=1: the entry fails if pslverr=1 or prdata≠expected. Go to NEXT.
  - Counter reaches TIMEOUT_CYCLES−1 without pready: entry fails as a timeout, psel/penable drop, go to NEXT.
- NEXT: psel=0.
  - If idx==N_INIT_REG−1, go to DONE.
  - Otherwise idx+1, then dispatch as above.
- DONE: o_done=1 and o_pass updated. Return to IDLE next cycle.
- Failure bookkeeping:
  - err_cnt increments with saturation at 255.
  - first_err_* are captured only when err_cnt was 0.
- Reset values:
  - All outputs 0, except o_pass=0 and o_apb_paddr=0.
  - State IDLE; counters 0.
- Reset mid-run: the bus is released immediately (psel=0) and status is cleared. No done pulse is issued.
- A start pulse received during busy is dropped, not queued.

## Timing
- Cycle 0: i_start sampled in IDLE. Cycle 1: first SETUP, or first NEXT if entry 0 is skipped.
- Non-skipped entry with zero-wait pready: 3 cycles (SETUP, ACCESS, NEXT).
- Skipped entry: 1 cycle (NEXT).
- Timed-out entry: 1 + TIMEOUT_CYCLES + 1 cycles.
- No skips, zero wait: o_done at cycle 3·N_INIT_REG+1. For N=20 that is cycle 61.
- Status outputs are registered. They are valid from the o_done cycle and held until the next start.
- o_apb_paddr is held stable through SETUP and ACCESS of each transfer.

## Structure
- Shared package: state enum; entry field helpers (addr=[63:32], data=[31:0]); the err_cnt width constant.
- Single module. The timeout counter and comparator are inline; no sub-module is warranted.

## Test plan
- All match: 20 entries with prdata equal to expected, pready immediate → o_done at cycle 61, o_pass=1, o_err_cnt=0, 20 read transfers with pwrite=0.
- Mismatch: entry 7 expected 0x0000_2329 returns 0x0000_2328, and entry 12 also mismatches → o_err_cnt=2, o_first_err_idx=7, o_first_err_data=0x0000_2328, o_pass=0.
- Skip and slave error: i_skip_mask=0x80000 (entry 19) and pslverr on entry 3 → 19 transfers on the bus, o_err_cnt=1, o_first_err_idx=3.
- Timeout: TIMEOUT_CYCLES=16 with pready never asserted for entry 0 → psel drops after 16 ACCESS cycles, o_first_err_data=0, the run continues and completes.
- Wait states: 3-cycle pready delay on every entry → done at cycle 5·20+1=101; paddr stable throughout each transfer.
- Reset and re-start: i_apb_rst_n asserted during ACCESS of entry 5 → psel=0 immediately and status cleared. A start during busy has no effect, and the next start after reset runs all 20 entries.
